// File: rtl/top_in_loader.sv
`default_nettype none
// ============================================================================
//  Module      : top_in_loader
//  Description : Upstream feeder for the top hierarchy. Buffers packed 9-bit
//                stimulus words in a small FIFO. Each word is unpacked onto
//                the top__* buses and held for a programmable number of
//                extra cycles before the next word is applied.
//  Revision    : 1.0 - initial release
// ============================================================================
module top_in_loader #(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8:0]               in_data,
    input  logic                     en,
    input  logic                     flush,
    input  logic [HOLD_W-1:0]        hold_cycles,
    output logic                     top__sub_a__s1,
    output logic [3:0]               top__sub_a__s2,
    output logic [1:0]               top__sub_a__ss1ss1ss1,
    output logic                     top__ssub_a__s2,
    output logic                     top__ssub_b__s3,
    output logic                     upd,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;
    localparam logic [c_lvl_w-1:0] c_full = c_lvl_w'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_lvl_w-1:0]   level_q, level_d;
    logic [8:0]           word_q, word_d;
    logic                 upd_q, upd_d;
    logic [8:0]           mem_q [DEPTH];

    logic                 push;
    logic                 pop;

    // A full FIFO never accepts, even if it pops this cycle: no push-through.
    assign in_ready = (level_q != c_full) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = !flush && (state_q == ST_IDLE) && en && (level_q != '0);

    // Next-state logic for FIFO bookkeeping, hold FSM and output word.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        word_d     = word_q;
        upd_d      = 1'b0;

        if (flush) begin
            // Flush drops everything buffered but leaves the applied word alone.
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
            end

            unique case (state_q)
                ST_IDLE: begin
                    hold_cnt_d = '0;
                    if (pop) begin
                        rd_ptr_d   = rd_ptr_q + c_ptr_w'(1);
                        word_d     = mem_q[rd_ptr_q];
                        upd_d      = 1'b1;
                        // hold_cycles is captured here only; later changes
                        // do not stretch or shorten the running hold.
                        hold_cnt_d = hold_cycles;
                        state_d    = (hold_cycles != '0) ? ST_HOLD : ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    // Counts down regardless of en; leaves on reaching zero.
                    if (hold_cnt_q <= HOLD_W'(1)) begin
                        hold_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end
            endcase

            unique case ({push, pop})
                2'b10:   level_d = level_q + c_lvl_w'(1);
                2'b01:   level_d = level_q - c_lvl_w'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // State registers; reset discards any buffered words immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            word_q     <= '0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            word_q     <= word_d;
            upd_q      <= upd_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign top__sub_a__s1        = word_q[0];
    assign top__sub_a__s2        = word_q[4:1];
    assign top__sub_a__ss1ss1ss1 = word_q[6:5];
    assign top__ssub_a__s2       = word_q[7];
    assign top__ssub_b__s3       = word_q[8];
    assign upd                   = upd_q;
    assign fifo_level            = level_q;

endmodule
`default_nettype wire
